// File: rtl/ps2_host_tx_if.sv
// Command side of the PS/2 host transmitter: byte request in, status pulses out.
// Handshake: tx_start is a one-cycle request taken only when busy=0 and done=0; done
// is a one-cycle pulse that qualifies ack_ok/error, and ack_ok holds until the next accept.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic [2:0] state;

  modport master (
    output tx_data, tx_start,
    input  busy, done, ack_ok, error, state
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, done, ack_ok, error, state
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, device-clocked
// frame (8 data, odd parity, stop), ACK sample and line release, with timeout abort.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          clock,
  input  logic          resetn,
  ps2_host_tx_if.slave  bus,
  inout  wire           ps2_clock,
  inout  wire           ps2_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    RTS     = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] RTS_LAST = 20'(RTS_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic [9:0]  frame;
  logic [3:0]  bitcnt;
  logic [19:0] cnt;
  logic        ack_flag;
  logic        clk_low, dat_low;
  logic        busy_r, done_r, ack_ok_r, error_r;
  logic        fall, tmo;

  assign fall = clk_prev & ~clk_s2;
  assign tmo  = (cnt == TO_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      frame    <= '0;
      bitcnt   <= '0;
      cnt      <= '0;
      ack_flag <= 1'b0;
      clk_low  <= 1'b0;
      dat_low  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ack_ok_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      clk_s1   <= ps2_clock;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      case (state)
        IDLE: begin
          busy_r  <= 1'b0;
          clk_low <= 1'b0;
          dat_low <= 1'b0;
          // No accept during the done cycle, so a new request lands one cycle later.
          if (bus.tx_start && !done_r) begin
            frame    <= {1'b1, ~^bus.tx_data, bus.tx_data};
            cnt      <= '0;
            bitcnt   <= '0;
            ack_flag <= 1'b0;
            ack_ok_r <= 1'b0;
            busy_r   <= 1'b1;
            clk_low  <= 1'b1;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt     <= '0;
            dat_low <= 1'b1;
            state   <= RTS;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        RTS: begin
          if (cnt == RTS_LAST) begin
            cnt     <= '0;
            bitcnt  <= '0;
            clk_low <= 1'b0;
            state   <= SEND;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        SEND: begin
          // The start bit is already on the line from RTS; each falling edge advances one bit.
          if (fall) begin
            cnt     <= '0;
            dat_low <= ~frame[bitcnt];
            bitcnt  <= bitcnt + 4'd1;
            if (bitcnt == 4'd9) state <= ACK;
          end else if (tmo) begin
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            done_r   <= 1'b1;
            error_r  <= 1'b1;
            ack_ok_r <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        ACK: begin
          if (fall) begin
            cnt      <= '0;
            ack_flag <= ~dat_s2;
            state    <= RELEASE;
          end else if (tmo) begin
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            done_r   <= 1'b1;
            error_r  <= 1'b1;
            ack_ok_r <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        RELEASE: begin
          if (clk_s2 && dat_s2) begin
            done_r   <= 1'b1;
            ack_ok_r <= ack_flag;
            error_r  <= ~ack_flag;
            state    <= IDLE;
          end else if (tmo) begin
            clk_low  <= 1'b0;
            dat_low  <= 1'b0;
            done_r   <= 1'b1;
            error_r  <= 1'b1;
            ack_ok_r <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ps2_clock  = clk_low ? 1'b0 : 1'bz;
  assign ps2_data   = dat_low ? 1'b0 : 1'bz;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.ack_ok = ack_ok_r;
  assign bus.error  = error_r;
  assign bus.state  = state;

endmodule
